// File: rtl/cpu_nbit_pkg.sv
// cpu_nbit_pkg: opcodes, mode encoding and next-PC helper for cpu_nbit
package cpu_nbit_pkg;
  localparam int OPC_W = 4;
  localparam logic [OPC_W-1:0] OP_ADDA  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_MOVAB = 4'b0001;
  localparam logic [OPC_W-1:0] OP_INA   = 4'b0010;
  localparam logic [OPC_W-1:0] OP_MOVA  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_MOVBA = 4'b0100;
  localparam logic [OPC_W-1:0] OP_ADDB  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_INB   = 4'b0110;
  localparam logic [OPC_W-1:0] OP_MOVB  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_OUTB  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_OUTI  = 4'b1011;
  localparam logic [OPC_W-1:0] OP_HLT   = 4'b1101;
  localparam logic [OPC_W-1:0] OP_JNC   = 4'b1110;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'b1111;
  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_RUN  = 1'b1;
  function automatic logic [31:0] next_pc(logic [OPC_W-1:0] op, logic c, logic [31:0] pc, logic [31:0] tgt);
    return op == OP_HLT ? pc : (op == OP_JMP || (op == OP_JNC && !c)) ? tgt : pc + 32'd1;
  endfunction
endpackage

// File: rtl/cpu_nbit_rise_edge.sv
// rise_edge: one-cycle pulse on a rising edge of a synchronous input
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic q;
  always_ff @(posedge clk) q <= rst ? 1'b0 : d;
  assign pulse = d & ~q;
endmodule

// File: rtl/cpu_nbit.sv
// cpu_nbit: TD4-style accumulator CPU with run/stop/step control and external ROM
module cpu_nbit
  import cpu_nbit_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MODESET,
  input  logic                    CPURST,
  input  logic                    STEPINC,
  input  logic                    SEC_SIG,
  input  logic [DATA_W-1:0]       RSW,
  input  logic [OPC_W+DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0]       PC_ADDR,
  output logic [DATA_W-1:0]       LED,
  output logic [DATA_W-1:0]       REG_A,
  output logic [DATA_W-1:0]       REG_B,
  output logic                    CARRY,
  output logic                    RUNNING,
  output logic                    HALTED
);
  logic ms, cr, st, se, exec, c, mode, halted;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [DATA_W-1:0] a, b, out, imm, a_n, b_n, out_n;
  logic [OPC_W-1:0] op;
  logic [DATA_W:0] sum_a, sum_b;
  logic c_n;
  rise_edge u_ms (.clk(CLK), .rst(RST), .d(MODESET), .pulse(ms));
  rise_edge u_cr (.clk(CLK), .rst(RST), .d(CPURST),  .pulse(cr));
  rise_edge u_st (.clk(CLK), .rst(RST), .d(STEPINC), .pulse(st));
  rise_edge u_se (.clk(CLK), .rst(RST), .d(SEC_SIG), .pulse(se));
  assign {op, imm} = INSTR;
  // exec uses the mode held before any same-cycle MODESET toggle
  assign exec = mode == MODE_RUN ? se : st;
  assign sum_a = {1'b0, a} + {1'b0, imm};
  assign sum_b = {1'b0, b} + {1'b0, imm};
  // jump target is the zero-extended or truncated immediate
  assign pc_n = ADDR_W'(next_pc(op, c, 32'(pc), 32'(imm)));
  always_comb begin
    a_n = op == OP_ADDA ? sum_a[DATA_W-1:0] : op == OP_MOVA ? imm : op == OP_MOVAB ? b : op == OP_INA ? RSW : a;
    b_n = op == OP_ADDB ? sum_b[DATA_W-1:0] : op == OP_MOVB ? imm : op == OP_MOVBA ? a : op == OP_INB ? RSW : b;
    out_n = op == OP_OUTB ? b : op == OP_OUTI ? imm : out;
    c_n = op == OP_ADDA ? sum_a[DATA_W] : op == OP_ADDB ? sum_b[DATA_W] : 1'b0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc <= '0;
      a <= '0;
      b <= '0;
      out <= '0;
      c <= 1'b0;
      mode <= MODE_STOP;
      halted <= 1'b0;
    end else begin
      if (ms) begin
        mode <= ~mode;
        halted <= 1'b0;
      end
      if (cr) begin
        pc <= '0;
        a <= '0;
        b <= '0;
        out <= '0;
        c <= 1'b0;
      end else if (exec) begin
        pc <= pc_n;
        a <= a_n;
        b <= b_n;
        out <= out_n;
        c <= c_n;
        if (op == OP_HLT) begin
          mode <= MODE_STOP;
          halted <= 1'b1;
        end
      end
    end
  end
  assign PC_ADDR = pc;
  assign LED = out;
  assign REG_A = a;
  assign REG_B = b;
  assign CARRY = c;
  assign RUNNING = mode == MODE_RUN;
  assign HALTED = halted;
endmodule

// File: tb/tb_cpu_nbit.sv
// tb_cpu_nbit: directed plan plus random control/ROM stress against a behavioural CPU model
module tb_cpu_nbit;
  logic CLK = 0, RST = 0, MODESET = 0, CPURST = 0, STEPINC = 0, SEC_SIG = 0;
  logic [3:0] RSW = 0, PC_ADDR, LED, REG_A, REG_B;
  logic [7:0] INSTR;
  logic CARRY, RUNNING, HALTED;
  logic [7:0] rom [16];
  int n_assert = 0, n_fail = 0;
  int m_pc, m_a, m_b, m_out, m_c, m_run, m_halt;
  int p_ms, p_cr, p_st, p_se;

  cpu_nbit #(.DATA_W(4), .ADDR_W(4)) dut (
    .CLK(CLK), .RST(RST), .MODESET(MODESET), .CPURST(CPURST), .STEPINC(STEPINC),
    .SEC_SIG(SEC_SIG), .RSW(RSW), .INSTR(INSTR), .PC_ADDR(PC_ADDR), .LED(LED),
    .REG_A(REG_A), .REG_B(REG_B), .CARRY(CARRY), .RUNNING(RUNNING), .HALTED(HALTED)
  );
  assign INSTR = rom[PC_ADDR];
  always #5 CLK = ~CLK;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic execute(logic [7:0] ins);
    int op, imm, s, npc, nc;
    op = ins / 16;
    imm = ins % 16;
    nc = 0;
    npc = (m_pc + 1) % 16;
    case (op)
      0: begin s = m_a + imm; m_a = s % 16; nc = s / 16; end
      5: begin s = m_b + imm; m_b = s % 16; nc = s / 16; end
      3: m_a = imm;
      7: m_b = imm;
      1: m_a = m_b;
      4: m_b = m_a;
      2: m_a = RSW;
      6: m_b = RSW;
      9: m_out = m_b;
      11: m_out = imm;
      15: npc = imm;
      14: npc = m_c ? npc : imm;
      13: begin npc = m_pc; m_run = 0; m_halt = 1; end
      default: ;
    endcase
    m_c = nc;
    m_pc = npc;
  endtask

  task automatic model_cycle();
    int e_ms, e_cr, e_st, e_se, ex;
    if (RST) begin
      {m_pc, m_a, m_b, m_out, m_c, m_run, m_halt} = '0;
      {p_ms, p_cr, p_st, p_se} = '0;
      return;
    end
    e_ms = MODESET && !p_ms;
    e_cr = CPURST && !p_cr;
    e_st = STEPINC && !p_st;
    e_se = SEC_SIG && !p_se;
    p_ms = MODESET; p_cr = CPURST; p_st = STEPINC; p_se = SEC_SIG;
    ex = m_run ? e_se : e_st;
    if (e_ms) begin m_run = !m_run; m_halt = 0; end
    if (e_cr) {m_pc, m_a, m_b, m_out, m_c} = '0;
    else if (ex) execute(rom[m_pc]);
  endtask

  task automatic cycle();
    logic [18:0] exp_v;
    model_cycle();
    @(posedge CLK);
    #1;
    exp_v = {4'(m_pc), 4'(m_out), 4'(m_a), 4'(m_b), 1'(m_c), 1'(m_run), 1'(m_halt)};
    check("state", 32'({PC_ADDR, LED, REG_A, REG_B, CARRY, RUNNING, HALTED}), 32'(exp_v));
  endtask

  task automatic pulse(input int which);
    case (which)
      0: MODESET = 1;
      1: CPURST = 1;
      2: STEPINC = 1;
      default: SEC_SIG = 1;
    endcase
    cycle();
    {MODESET, CPURST, STEPINC, SEC_SIG} = '0;
    cycle();
  endtask

  task automatic fill_rom(logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  initial begin
    fill_rom(8'h80);
    // 1: reset and idle in STOP
    RST = 1;
    cycle();
    cycle();
    RST = 0;
    cycle();
    check("rst_pc", PC_ADDR, 0);
    check("rst_led", LED, 0);
    check("rst_a", REG_A, 0);
    check("rst_c", CARRY, 0);
    check("rst_run", RUNNING, 0);
    pulse(3);
    pulse(3);
    check("stop_sec_pc", PC_ADDR, 0);
    // 2: RUN program with JNC not taken and HLT
    rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE0; rom[3] = 8'hB5; rom[4] = 8'hD0;
    pulse(0);
    check("run_on", RUNNING, 1);
    pulse(3);
    check("p2_a3", REG_A, 3);
    pulse(3);
    check("p2_a1", REG_A, 1);
    check("p2_c1", CARRY, 1);
    pulse(3);
    check("p2_jnc_pc", PC_ADDR, 3);
    check("p2_c0", CARRY, 0);
    pulse(3);
    check("p2_led", LED, 5);
    pulse(3);
    check("p2_hlt_run", RUNNING, 0);
    check("p2_hlt_halted", HALTED, 1);
    check("p2_hlt_pc", PC_ADDR, 4);
    pulse(3);
    check("p2_hlt_hold", PC_ADDR, 4);
    // 3: single step in STOP
    fill_rom(8'h80);
    rom[0] = 8'h27; rom[1] = 8'h91; rom[2] = 8'hF0;
    RSW = 4'hA;
    pulse(1);
    check("cpurst_pc", PC_ADDR, 0);
    pulse(2);
    check("p3_a", REG_A, 4'hA);
    pulse(3);
    check("p3_sec_ignored", PC_ADDR, 1);
    pulse(2);
    check("p3_led", LED, 0);
    pulse(2);
    check("p3_jmp", PC_ADDR, 0);
    // 4: JNC taken and PC wrap
    rom[0] = 8'h31; rom[1] = 8'hE5; rom[5] = 8'hFF; rom[15] = 8'h80;
    pulse(2);
    pulse(2);
    check("p4_jnc_taken", PC_ADDR, 5);
    pulse(2);
    check("p4_jmp_f", PC_ADDR, 15);
    pulse(2);
    check("p4_wrap", PC_ADDR, 0);
    // 5: CPURST and SEC_SIG together in RUN
    fill_rom(8'h80);
    rom[0] = 8'h35; rom[1] = 8'h76; rom[2] = 8'h90; rom[3] = 8'h0F;
    pulse(0);
    for (int i = 0; i < 4; i++) pulse(3);
    check("p5_pre_c", CARRY, 1);
    check("p5_pre_led", LED, 6);
    CPURST = 1; SEC_SIG = 1;
    cycle();
    {CPURST, SEC_SIG} = '0;
    check("p5_pc", PC_ADDR, 0);
    check("p5_regs", {LED, REG_A, REG_B, CARRY}, 0);
    check("p5_run", RUNNING, 1);
    cycle();
    // 6: MODESET and STEPINC together in STOP
    pulse(0);
    rom[0] = 8'hD0;
    pulse(2);
    check("p6_halted", HALTED, 1);
    rom[0] = 8'h39;
    MODESET = 1; STEPINC = 1;
    cycle();
    {MODESET, STEPINC} = '0;
    check("p6_a", REG_A, 9);
    check("p6_pc", PC_ADDR, 1);
    check("p6_run", RUNNING, 1);
    check("p6_halted_clr", HALTED, 0);
    cycle();
    // random stress
    for (int i = 0; i < 3000; i++) begin
      if (i % 256 == 0) for (int j = 0; j < 16; j++) rom[j] = 8'($urandom);
      RST = $urandom_range(0, 299) == 0;
      MODESET = $urandom_range(0, 9) == 0;
      CPURST = $urandom_range(0, 29) == 0;
      STEPINC = 1'($urandom);
      SEC_SIG = 1'($urandom);
      RSW = 4'($urandom);
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
